// File: rtl/bw_io_hstl_zcal_if.sv
// Calibration request/status and code bus between the HSTL zcal controller and its
// neighbours: the replica driver, the comparator and the HSTL pad drivers.
interface bw_io_hstl_zcal_if;
    logic       cal_start;
    logic       cal_en;
    logic       pu_comp_hi;
    logic       pd_comp_hi;
    logic       upd_ok;
    logic       rep_sel;
    logic [8:1] rep_cbu;
    logic [8:1] rep_cbd;
    logic [8:1] cbu;
    logic [8:1] cbd;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_err;

    modport master (
        output cal_start, cal_en, pu_comp_hi, pd_comp_hi, upd_ok,
        input  rep_sel, rep_cbu, rep_cbd, cbu, cbd, cal_busy, cal_done, cal_err
    );

    modport slave (
        input  cal_start, cal_en, pu_comp_hi, pd_comp_hi, upd_ok,
        output rep_sel, rep_cbu, rep_cbd, cbu, cbd, cal_busy, cal_done, cal_err
    );
endinterface

// File: rtl/bw_io_hstl_zcal_ctl.sv
// HSTL impedance calibration: steps pull-up then pull-down replica leg counts until the
// comparator flips, then broadcasts both thermometer codes inside a driver-quiet window.
module bw_io_hstl_zcal_ctl #(
    parameter int SETTLE_CYC = 8,
    parameter int PERIOD_CYC = 4096,
    parameter int MAX_ITER   = 16,
    parameter int INIT_CODE  = 4
) (
    input logic             clk,
    input logic             rst,
    bw_io_hstl_zcal_if.slave zif
);

    typedef enum logic [2:0] {
        IDLE, PU_SETTLE, PU_CMP, PD_SETTLE, PD_CMP, UPDATE
    } state_t;

    function automatic logic [8:1] thermo(input logic [3:0] c);
        logic [8:1] t;
        for (int k = 1; k <= 8; k++) t[k] = (c >= 4'(k));
        return t;
    endfunction

    state_t      state;
    logic [3:0]  pu_cnt;
    logic [3:0]  pd_cnt;
    logic [7:0]  settle_cnt;
    logic [15:0] timer;
    logic [4:0]  iter;
    logic        have_dir;
    logic        last_up;

    // Both compare states share one step/lock decision; only the operands differ.
    logic       cmp_pd;
    logic [3:0] cur_cnt;
    logic       dir_up;
    logic [3:0] step_cnt;
    logic       lock_rev;
    logic       lock_sat;
    logic       lock_lim;
    logic       lock;
    logic       start_req;

    assign cmp_pd    = (state == PD_CMP);
    assign cur_cnt   = cmp_pd ? pd_cnt : pu_cnt;
    assign dir_up    = cmp_pd ? zif.pd_comp_hi : zif.pu_comp_hi;
    assign step_cnt  = dir_up ? cur_cnt + 4'd1 : cur_cnt - 4'd1;
    assign lock_rev  = have_dir && (dir_up != last_up);
    assign lock_sat  = dir_up ? (cur_cnt == 4'd8) : (cur_cnt == 4'd0);
    assign lock_lim  = (iter == 5'(MAX_ITER - 1));
    assign lock      = lock_rev || lock_sat || lock_lim;
    assign start_req = zif.cal_start || (zif.cal_en && timer == 16'(PERIOD_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pu_cnt       <= 4'(INIT_CODE);
            pd_cnt       <= 4'(INIT_CODE);
            settle_cnt   <= '0;
            timer        <= '0;
            iter         <= '0;
            have_dir     <= 1'b0;
            last_up      <= 1'b0;
            zif.rep_sel  <= 1'b0;
            zif.rep_cbu  <= thermo(4'(INIT_CODE));
            zif.rep_cbd  <= thermo(4'(INIT_CODE));
            zif.cbu      <= thermo(4'(INIT_CODE));
            zif.cbd      <= thermo(4'(INIT_CODE));
            zif.cal_busy <= 1'b0;
            zif.cal_done <= 1'b0;
            zif.cal_err  <= 1'b0;
        end else begin
            zif.cal_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A simultaneous manual and periodic request collapse into one run.
                    if (start_req) begin
                        state        <= PU_SETTLE;
                        timer        <= '0;
                        iter         <= '0;
                        have_dir     <= 1'b0;
                        settle_cnt   <= '0;
                        zif.cal_err  <= 1'b0;
                        zif.cal_busy <= 1'b1;
                        zif.rep_sel  <= 1'b0;
                    end else if (zif.cal_en) begin
                        timer <= timer + 16'd1;
                    end
                end
                PU_SETTLE, PD_SETTLE: begin
                    if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
                        settle_cnt <= '0;
                        state      <= (state == PU_SETTLE) ? PU_CMP : PD_CMP;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                PU_CMP, PD_CMP: begin
                    if (lock) begin
                        iter     <= '0;
                        have_dir <= 1'b0;
                        if (!lock_rev) zif.cal_err <= 1'b1;
                        if (cmp_pd) begin
                            state <= UPDATE;
                        end else begin
                            state       <= PD_SETTLE;
                            zif.rep_sel <= 1'b1;
                        end
                    end else begin
                        if (cmp_pd) begin
                            pd_cnt      <= step_cnt;
                            zif.rep_cbd <= thermo(step_cnt);
                            state       <= PD_SETTLE;
                        end else begin
                            pu_cnt      <= step_cnt;
                            zif.rep_cbu <= thermo(step_cnt);
                            state       <= PU_SETTLE;
                        end
                        last_up  <= dir_up;
                        have_dir <= 1'b1;
                        iter     <= iter + 5'd1;
                    end
                end
                UPDATE: begin
                    // Drivers see only the final codes, and only while they are quiet.
                    if (zif.upd_ok) begin
                        zif.cbu      <= thermo(pu_cnt);
                        zif.cbd      <= thermo(pd_cnt);
                        zif.cal_done <= 1'b1;
                        zif.cal_busy <= 1'b0;
                        zif.rep_sel  <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_io_hstl_zcal_ctl.sv
// Directed bench for bw_io_hstl_zcal_ctl: two instances (generous and tight iteration limit)
// with a threshold comparator model driven from the replica codes.
module tb_bw_io_hstl_zcal_ctl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bw_io_hstl_zcal_if za();
    bw_io_hstl_zcal_if zb();

    // Replica "too high" while the leg count is at or below the threshold.
    int pu_thr_a = 5, pd_thr_a = 3, pu_thr_b = 4, pd_thr_b = -1;
    assign za.pu_comp_hi = ($countones(za.rep_cbu) <= pu_thr_a);
    assign za.pd_comp_hi = ($countones(za.rep_cbd) <= pd_thr_a);
    assign zb.pu_comp_hi = ($countones(zb.rep_cbu) <= pu_thr_b);
    assign zb.pd_comp_hi = ($countones(zb.rep_cbd) <= pd_thr_b);

    bw_io_hstl_zcal_ctl #(.SETTLE_CYC(2), .PERIOD_CYC(16), .MAX_ITER(16), .INIT_CODE(4))
        dut_a (.clk(clk), .rst(rst), .zif(za));
    bw_io_hstl_zcal_ctl #(.SETTLE_CYC(2), .PERIOD_CYC(4096), .MAX_ITER(3), .INIT_CODE(4))
        dut_b (.clk(clk), .rst(rst), .zif(zb));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit b);
        if (b) zb.cal_start = 1'b1; else za.cal_start = 1'b1;
        tick();
        za.cal_start = 1'b0;
        zb.cal_start = 1'b0;
        chk("start_busy", b ? zb.cal_busy : za.cal_busy, 1);
    endtask

    // Waits for cal_done, counting edges on which the broadcast codes moved.
    task automatic wait_done(input bit b, input int budget, output int chg);
        logic [15:0] prev, cur;
        bit seen;
        prev = b ? {zb.cbu, zb.cbd} : {za.cbu, za.cbd};
        chg  = 0;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            cur = b ? {zb.cbu, zb.cbd} : {za.cbu, za.cbd};
            if (cur !== prev) chg++;
            prev = cur;
            seen = b ? zb.cal_done : za.cal_done;
        end
        chk("done_seen", 32'(seen), 1);
    endtask

    initial begin
        int chg, n, dones;
        za.cal_start = 0; za.cal_en = 0; za.upd_ok = 1;
        zb.cal_start = 0; zb.cal_en = 0; zb.upd_ok = 1;

        // Reset defaults
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cbu", za.cbu, 8'h0F);
        chk("rst_cbd", za.cbd, 8'h0F);
        chk("rst_rep_cbu", za.rep_cbu, 8'h0F);
        chk("rst_rep_cbd", za.rep_cbd, 8'h0F);
        chk("rst_busy", za.cal_busy, 0);
        chk("rst_done", za.cal_done, 0);
        chk("rst_err", za.cal_err, 0);
        chk("rst_b_cbd", zb.cbd, 8'h0F);

        // Normal lock: pu 4->5->6 then reverses, pd 4->3 then reverses
        start(0);
        chk("norm_cbu_held", za.cbu, 8'h0F);
        wait_done(0, 100, chg);
        chk("norm_cbu", za.cbu, 8'h3F);
        chk("norm_cbd", za.cbd, 8'h07);
        chk("norm_err", za.cal_err, 0);
        chk("norm_one_edge", chg, 1);
        chk("norm_rep_cbu", za.rep_cbu, 8'h3F);
        tick();
        chk("norm_done_pulse", za.cal_done, 0);
        chk("norm_idle", za.cal_busy, 0);

        // Saturation: pu stuck high climbs 6->7->8 then errors; pd 3->4 then reverses
        pu_thr_a = 8;
        start(0);
        wait_done(0, 100, chg);
        chk("sat_cbu", za.cbu, 8'hFF);
        chk("sat_cbd", za.cbd, 8'h0F);
        chk("sat_err", za.cal_err, 1);
        tick();
        chk("sat_err_sticky", za.cal_err, 1);

        // Update gating: pu 8->7->6->5 locks at 5, pd 4->3 locks at 3, held by upd_ok=0
        pu_thr_a = 5;
        za.upd_ok = 1'b0;
        start(0);
        dones = 0; chg = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (za.cal_done) dones++;
            if (za.cbu !== 8'hFF || za.cbd !== 8'h0F) chg++;
        end
        chk("gate_busy", za.cal_busy, 1);
        chk("gate_no_done", dones, 0);
        chk("gate_codes_held", chg, 0);
        chk("gate_err_cleared", za.cal_err, 0);
        za.upd_ok = 1'b1;
        tick();
        chk("gate_done", za.cal_done, 1);
        chk("gate_cbu", za.cbu, 8'h1F);
        chk("gate_cbd", za.cbd, 8'h07);
        tick();
        chk("gate_done_pulse", za.cal_done, 0);
        chk("gate_idle", za.cal_busy, 0);

        // Iteration limit on the MAX_ITER=3 instance: pd 4->3->2 then forced lock
        start(1);
        wait_done(1, 100, chg);
        chk("iter_cbd", zb.cbd, 8'h03);
        chk("iter_cbu", zb.cbu, 8'h1F);
        chk("iter_err", zb.cal_err, 1);

        // Periodic start on the 16th idle cycle
        za.cal_en = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && !za.cal_busy; i++) begin
            tick();
            n++;
        end
        chk("period_start", n, 16);

        // Start while busy is dropped: one done, no restart afterwards
        za.cal_start = 1'b1;
        tick();
        za.cal_start = 1'b0;
        wait_done(0, 100, chg);
        chk("drop_cbu", za.cbu, 8'h3F);
        chk("drop_cbd", za.cbd, 8'h0F);
        tick();
        chk("drop_not_queued", za.cal_busy, 0);
        chk("drop_done_once", za.cal_done, 0);

        // Abort: next periodic run, reset while in PD_CMP
        for (int i = 0; i < 40 && !za.cal_busy; i++) tick();
        chk("abort_started", za.cal_busy, 1);
        for (int i = 0; i < 40 && !za.rep_sel; i++) tick();
        chk("abort_pd_phase", za.rep_sel, 1);
        tick(); tick();
        rst = 1'b1;
        za.cal_en = 1'b0;
        tick();
        chk("abort_cbu", za.cbu, 8'h0F);
        chk("abort_cbd", za.cbd, 8'h0F);
        chk("abort_rep_cbu", za.rep_cbu, 8'h0F);
        chk("abort_rep_cbd", za.rep_cbd, 8'h0F);
        chk("abort_rep_sel", za.rep_sel, 0);
        chk("abort_busy", za.cal_busy, 0);
        chk("abort_err", za.cal_err, 0);
        chk("abort_done", za.cal_done, 0);
        rst = 1'b0;
        tick();
        chk("abort_idle", za.cal_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bw_io_hstl_zcal_ctl.md
Name: bw_io_hstl_zcal_ctl

Overview:
Impedance-calibration controller for the HSTL pad drivers. It steps a pull-up and a pull-down replica leg code against external comparator results until each code locks, then broadcasts the locked codes to all HSTL drivers as cbu[8:1]/cbd[8:1]. Codes change only inside a driver-quiet window. It sits in the pad_misc block, one instance per HSTL pad group, next to the replica driver and the comparator.

Parameters:
SETTLE_CYC, 8, cycles waited after each replica code change before the comparator is sampled (1..255)
PERIOD_CYC, 4096, idle cycles between automatic recalibrations when cal_en=1 (2..65535)
MAX_ITER, 16, maximum compare steps per phase before forced lock with error (1..31)
INIT_CODE, 4, reset leg count for both codes (0..8)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
cal_start  in  1  one-cycle request for immediate calibration; ignored while busy
cal_en  in  1  enables periodic recalibration
pu_comp_hi  in  1  comparator result for the pull-up replica; 1 = impedance too high
pd_comp_hi  in  1  comparator result for the pull-down replica; 1 = impedance too high
upd_ok  in  1  driver-quiet window; codes may be broadcast in this cycle
rep_sel  out  1  replica select: 0 = pull-up phase, 1 = pull-down phase
rep_cbu  out  8  pull-up replica code, thermometer
rep_cbd  out  8  pull-down replica code, thermometer
cbu  out  8  broadcast pull-up code to drivers, thermometer
cbd  out  8  broadcast pull-down code to drivers, thermometer
cal_busy  out  1  high in every non-IDLE state
cal_done  out  1  one-cycle pulse when codes are broadcast
cal_err  out  1  sticky error; cleared when the next calibration starts

Behaviour:
- Codes: 4-bit counts pu_cnt and pd_cnt, range 0..8. Thermometer output: bit k (k = 1..8) = (cnt >= k). Example: count 4 -> 8'h0F.
- Reset values: pu_cnt = pd_cnt = INIT_CODE. rep_cbu, rep_cbd, cbu and cbd all equal thermo(INIT_CODE). State IDLE. rep_sel=0, cal_busy=0, cal_done=0, cal_err=0. Period timer=0.
- Reset in the middle of a calibration aborts it; every output returns to its reset value on the next edge.
- States: IDLE, PU_SETTLE, PU_CMP, PD_SETTLE, PD_CMP, UPDATE.
- IDLE:
  - The period timer increments while cal_en=1 and holds while cal_en=0.
  - Calibration starts on cal_start=1, or when cal_en=1 and timer = PERIOD_CYC-1.
  - On start: go to PU_SETTLE, clear the timer, clear cal_err, clear the iteration counter and the last-direction flag.
  - If both start conditions are true in the same cycle, only one calibration runs.
- PU_SETTLE: settle counter runs SETTLE_CYC cycles, then go to PU_CMP. rep_sel=0.
- PU_CMP samples pu_comp_hi for exactly one cycle. Direction dir = up if pu_comp_hi=1, else down.
  - (a) A previous direction exists this phase and dir differs from it: lock. Code unchanged.
  - (b) dir=up with cnt=8, or dir=down with cnt=0: lock. Set cal_err.
  - (c) Iteration count = MAX_ITER-1: lock. Set cal_err. Code unchanged.
  - Otherwise: step cnt by +1 or -1, record dir, increment the iteration count, return to PU_SETTLE.
  - On lock: go to PD_SETTLE, clear the iteration counter and the last-direction flag.
- PD_SETTLE and PD_CMP: identical to the pull-up phase, using pd_cnt, pd_comp_hi and rep_sel=1. On lock, go to UPDATE.
- Replica outputs: rep_cbu and rep_cbd are registered and reflect the counts one cycle after each step.
- UPDATE:
  - Hold while upd_ok=0.
  - In the first cycle with upd_ok=1: cbu <= thermo(pu_cnt), cbd <= thermo(pd_cnt), cal_done=1 next cycle for one cycle, state goes to IDLE.
- cbu and cbd change only on that UPDATE edge (or on reset). They never show intermediate codes.
- cal_start while cal_busy=1 is dropped, not queued.
- cal_err stays set through UPDATE. The codes are still broadcast when cal_err is set.

Test Plan:
- Reset defaults: rst=1 for 2 cycles, then release -> cbu = cbd = rep_cbu = rep_cbd = 8'h0F; cal_busy=0, cal_done=0, cal_err=0.
- Normal lock, SETTLE_CYC=2, upd_ok=1:
  - Stimulus: pu_comp_hi=1 for two compares then 0; pd_comp_hi=0 for one compare then 1.
  - Response: pu locks at 6 (cbu=8'h3F), pd locks at 3 (cbd=8'h07). cal_done pulses once; cal_err=0; cbu/cbd change on exactly one edge.
- Saturation: pu_comp_hi stuck at 1 -> pu_cnt climbs to 8, then locks with cal_err=1. cbu=8'hFF after UPDATE.
- Iteration limit: MAX_ITER=3, pd_comp_hi=0 -> pd_cnt 4 -> 3 -> 2, then locks with cal_err=1. cbd=8'h03.
- Update gating: upd_ok=0 for 20 cycles after lock.
  - Response: state stays UPDATE, cbu/cbd unchanged, cal_busy=1.
  - Assert upd_ok=1 -> codes load and cal_done pulses the next cycle.
- Periodic, abort and dropped start, PERIOD_CYC=16, cal_en=1:
  - Calibration starts at the 16th idle cycle.
  - cal_start during busy is ignored: exactly one cal_done.
  - rst during PD_CMP -> all outputs return to reset values, state IDLE.
